// File: rtl/fp32_pkg.sv
// Shared constants and inter-stage payload for the FP32 add/normalize/round pipeline.
package fp32_pkg;

  localparam logic [7:0]  FP32_EXP_MAX = 8'd255;
  localparam int unsigned FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [30:0] FP32_INF     = 31'h7F800000;

  // exp is 9 bits so a carry into 255+ survives until the overflow check.
  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [25:0] mant;
    logic        guard;
    logic        sticky;
    logic        exc;
    logic        uflow;
  } fp32_stage_t;

endpackage

// File: rtl/fp32_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input yields 25.
module fp32_lzc (
  input  logic [24:0] data_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (data_i[i]) count_o = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fp32_add_norm.sv
// Three-stage FP32 significand add, normalize and round-to-nearest-even with valid/ready
// handshake; the whole pipe advances together and stalls on output back-pressure.
module fp32_add_norm
  import fp32_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID_SINGLE,
  output logic        IN_READY_SINGLE,
  input  logic        IN_SIGN_A_SINGLE,
  input  logic        IN_SIGN_B_SINGLE,
  input  logic [23:0] IN_MANT_A_SINGLE,
  input  logic [23:0] IN_MANT_B_SINGLE,
  input  logic [7:0]  IN_EXP_SINGLE,
  input  logic        IN_GUARD_BIT,
  input  logic        IN_STICKY_BIT,
  input  logic        IN_EXCEPTION_SINGLE,
  output logic        OUT_VALID_SINGLE,
  input  logic        OUT_READY_SINGLE,
  output logic [31:0] OUT_RESULT_SINGLE,
  output logic        OUT_OVERFLOW_SINGLE,
  output logic        OUT_UNDERFLOW_SINGLE
);

  logic        adv;
  logic        s1_v_q, s2_v_q, out_valid_q;
  fp32_stage_t s1_d, s1_q, s2_d, s2_q;
  logic [31:0] res_d, res_q;
  logic        ovf_d, ovf_q, unf_d, unf_q;

  assign adv             = ~out_valid_q | OUT_READY_SINGLE;
  assign IN_READY_SINGLE = adv | RST;

  // S1: effective add/subtract; guard/sticky extend the smaller significand.
  logic        eff_sub, a_gt_b;
  logic [24:0] sum;
  logic [25:0] ext_diff;

  always_comb begin
    eff_sub  = IN_SIGN_A_SINGLE ^ IN_SIGN_B_SINGLE;
    a_gt_b   = IN_MANT_A_SINGLE > IN_MANT_B_SINGLE;
    sum      = {1'b0, IN_MANT_A_SINGLE} + {1'b0, IN_MANT_B_SINGLE};
    ext_diff = a_gt_b ?
        {IN_MANT_A_SINGLE, 2'b00} - {IN_MANT_B_SINGLE, IN_GUARD_BIT, IN_STICKY_BIT} :
        {IN_MANT_B_SINGLE, 2'b00} - {IN_MANT_A_SINGLE, IN_GUARD_BIT, IN_STICKY_BIT};
    s1_d        = '0;
    s1_d.exp    = {1'b0, IN_EXP_SINGLE};
    s1_d.exc    = IN_EXCEPTION_SINGLE;
    s1_d.guard  = IN_GUARD_BIT;
    s1_d.sticky = IN_STICKY_BIT;
    if (!eff_sub) begin
      s1_d.sign = IN_SIGN_A_SINGLE;
      s1_d.mant = {1'b0, sum};
    end else if (IN_MANT_A_SINGLE == IN_MANT_B_SINGLE) begin
      // Only the shifted-out bits remain; an exact cancel is +0.
      s1_d.sign = IN_SIGN_B_SINGLE & (IN_GUARD_BIT | IN_STICKY_BIT);
      s1_d.mant = '0;
    end else begin
      s1_d.sign   = a_gt_b ? IN_SIGN_A_SINGLE : IN_SIGN_B_SINGLE;
      s1_d.mant   = {2'b00, ext_diff[25:2]};
      s1_d.guard  = ext_diff[1];
      s1_d.sticky = ext_diff[0];
    end
  end

  // S2: normalize.
  logic [24:0] lz_in, shl;
  logic [4:0]  lz;
  logic        zero_mag;

  assign lz_in = {s1_q.mant[23:0], s1_q.guard};

  fp32_lzc u_lzc (
    .data_i  (lz_in),
    .count_o (lz)
  );

  always_comb begin
    s2_d       = s1_q;
    s2_d.uflow = 1'b0;
    shl        = lz_in << lz;
    zero_mag   = ~|lz_in & ~s1_q.mant[24];
    if (s1_q.mant[24]) begin
      s2_d.mant   = {2'b00, s1_q.mant[24:1]};
      s2_d.guard  = s1_q.mant[0];
      s2_d.sticky = s1_q.sticky | s1_q.guard;
      s2_d.exp    = s1_q.exp + 9'd1;
    end else if (zero_mag && !s1_q.sticky) begin
      s2_d.mant   = '0;
      s2_d.guard  = 1'b0;
      s2_d.sticky = 1'b0;
      s2_d.exp    = '0;
    end else if (zero_mag || ({4'b0, lz} >= s1_q.exp)) begin
      s2_d.uflow = 1'b1;
    end else begin
      s2_d.mant   = {2'b00, shl[24:1]};
      s2_d.guard  = shl[0];
      s2_d.sticky = s1_q.sticky;
      s2_d.exp    = s1_q.exp - {4'b0, lz};
    end
  end

  // S3: round to nearest-even and pack.
  logic        round_up;
  logic [24:0] rnd;
  logic [23:0] mant_r;
  logic [8:0]  exp_r;
  logic        unused_bits;

  assign unused_bits = ^{s2_q.mant[25:24], mant_r[23]};

  always_comb begin
    round_up = s2_q.guard & (s2_q.sticky | s2_q.mant[0]);
    rnd      = {1'b0, s2_q.mant[23:0]} + {24'b0, round_up};
    if (rnd[24]) begin
      mant_r = rnd[24:1];
      exp_r  = s2_q.exp + 9'd1;
    end else begin
      mant_r = rnd[23:0];
      exp_r  = s2_q.exp;
    end
    res_d = {s2_q.sign, exp_r[7:0], mant_r[22:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_q.exc) begin
      res_d = FP32_QNAN;
    end else if (s2_q.uflow) begin
      res_d = {s2_q.sign, 31'b0};
      unf_d = 1'b1;
    end else if (exp_r >= {1'b0, FP32_EXP_MAX}) begin
      res_d = {s2_q.sign, FP32_INF};
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (adv) begin
      s1_v_q      <= IN_VALID_SINGLE;
      s2_v_q      <= s1_v_q;
      out_valid_q <= s2_v_q;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign OUT_VALID_SINGLE     = out_valid_q;
  assign OUT_RESULT_SINGLE    = res_q;
  assign OUT_OVERFLOW_SINGLE  = ovf_q;
  assign OUT_UNDERFLOW_SINGLE = unf_q;

endmodule

// File: doc/fp32_add_norm.md
# fp32_add_norm

Pipelined FP32 significand add, normalize and round stage that sits directly downstream of the single-precision alignment stage. It consumes operands that share a common exponent, adds or subtracts their significands, renormalizes, and rounds to nearest-even. It emits a packed IEEE-754 single-precision result over a valid/ready handshake. Fixed latency is 3 cycles; the whole pipeline stalls under back-pressure.

## Interface
Parameters: none. Widths are fixed by FP32.

- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID_SINGLE  in  1  input operand set valid
- IN_READY_SINGLE  out  1  stage can accept input this cycle
- IN_SIGN_A_SINGLE  in  1  sign of operand A
- IN_SIGN_B_SINGLE  in  1  sign of operand B
- IN_MANT_A_SINGLE  in  24  aligned significand A, hidden bit at [23]
- IN_MANT_B_SINGLE  in  24  aligned significand B, hidden bit at [23]
- IN_EXP_SINGLE  in  8  common biased exponent
- IN_GUARD_BIT  in  1  first bit shifted out during alignment
- IN_STICKY_BIT  in  1  OR of all remaining shifted-out bits
- IN_EXCEPTION_SINGLE  in  1  an operand had exponent 255
- OUT_VALID_SINGLE  out  1  result valid
- OUT_READY_SINGLE  in  1  downstream accepts result
- OUT_RESULT_SINGLE  out  32  packed {sign, exp[7:0], frac[22:0]}
- OUT_OVERFLOW_SINGLE  out  1  result rounded to infinity
- OUT_UNDERFLOW_SINGLE  out  1  result flushed to zero

## Operation
- Transfer in: IN_VALID_SINGLE & IN_READY_SINGLE. Transfer out: OUT_VALID_SINGLE & OUT_READY_SINGLE.
- Global advance: ADV = ~OUT_VALID_SINGLE | OUT_READY_SINGLE. IN_READY_SINGLE = ADV.
- When ADV=0, all stage registers and valid bits hold.

**Stage 1 (S1, add)**
- Effective operation is a subtract when the signs differ.
- Add: sum[24:0] = A + B, sign = sign A.
- Subtract: subtract the smaller magnitude from the larger, giving a 25-bit magnitude. Sign is the sign of the larger operand.
- For a subtract, guard and sticky belong to the shifted (smaller) operand and are borrowed: the magnitude is computed on the 26-bit value {mant, G, S}.

**Stage 2 (S2, normalize)**
- If sum[24]=1: shift right 1. New guard = old LSB. Sticky |= guard. exp + 1.
- Else: count leading zeros L over the 24-bit field plus guard, then shift left by L and fill with zeros. exp − L.
- If L ≥ exp: result is flushed to ±0 and the underflow flag is set. Denormals are not produced.
- Exact zero magnitude: result +0x00000000. The sign is 1 only when both inputs are negative under an effective add.

**Stage 3 (S3, round and pack)**
- Round up when G & (S | LSB).
- A mantissa carry-out on rounding shifts right 1 and increments exp.
- If exp ≥ 255 after rounding: output ±0x7F800000 with overflow=1.
- If IN_EXCEPTION_SINGLE was set: output 0x7FC00000 (qNaN), both flags 0. The arithmetic result is ignored.

## Timing
- Latency: a result appears exactly 3 ADV cycles after acceptance. Throughput is 1 per cycle when never stalled.
- Reset values: OUT_VALID_SINGLE=0, OUT_RESULT_SINGLE=0, OUT_OVERFLOW_SINGLE=0, OUT_UNDERFLOW_SINGLE=0, all internal valid bits 0.
- IN_READY_SINGLE=1 during and immediately after reset.
- Reset mid-operation discards all in-flight items; no partial result is emitted.
- OUT_RESULT_SINGLE and the flags are stable while OUT_VALID_SINGLE=1 and OUT_READY_SINGLE=0.
- Simultaneous input accept and output drain with a full pipe is lossless: ADV=1 shifts every stage.
- Bubbles (invalid slots) propagate; data in a bubble is don't-care, but its valid bit must be 0.

## Structure
- Package fp32_pkg holds:
  - FP32_EXP_MAX = 8'd255, FP32_BIAS = 127
  - FP32_QNAN = 32'h7FC00000, FP32_INF = 31'h7F800000
  - a packed struct for the S1→S2 and S2→S3 payload: sign, exp, 26-bit magnitude/extended mantissa, guard, sticky, exception
- Sub-module fp32_lzc: combinational 25-bit leading-zero counter with a 5-bit output; an all-zero input returns 25.

## Test plan
- 1.0+1.0: A=B=0x800000, exp=127, signs 0, G=S=0 → after 3 cycles 0x40000000, flags 0.
- 1.5+(−1.5): A=B=0xC00000, sign B=1, exp=127 → 0x00000000, underflow=0.
- Tie-to-even: A=0x800001, B=0x000000, G=1, S=0, exp=127 → 0x3F800002. The same input with A=0x800000 → 0x3F800000.
- Overflow: A=B=0xFFFFFF, exp=254, G=1 → 0x7F800000, overflow=1. Exception input with any data → 0x7FC00000.
- Back-pressure: stream 5 valid inputs, hold OUT_READY_SINGLE=0 from cycle 3 for 4 cycles → IN_READY_SINGLE=0 during the stall, output held stable, all 5 results delivered in order with none dropped or duplicated.
- Assert RST with 3 items in flight → next cycle OUT_VALID_SINGLE=0. After release, a new 1.0+1.0 produces 0x40000000 at latency 3.
